// File: rtl/d5m_pkg.sv
// Shared types, widths and the colour packing helper for the D5M Bayer-to-RGB565 converter.
package d5m_pkg;

    localparam int unsigned RAW_W  = 12;
    localparam int unsigned R_W    = 5;
    localparam int unsigned G_W    = 6;
    localparam int unsigned B_W    = 5;
    localparam int unsigned RGB_W  = R_W + G_W + B_W;
    localparam int unsigned GSUM_W = RAW_W + 1;

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_LINE,
        EVEN_LINE,
        ODD_LINE
    } state_e;

    // Truncating conversion: top bits of R and B, top bits of the 13-bit green sum.
    function automatic logic [RGB_W-1:0] pack_rgb565(
        input logic [RAW_W-1:0] r,
        input logic [RAW_W-1:0] g1,
        input logic [RAW_W-1:0] g2,
        input logic [RAW_W-1:0] b
    );
        logic [GSUM_W-1:0] gsum;
        gsum = GSUM_W'(g1) + GSUM_W'(g2);
        return {R_W'(r >> (RAW_W - R_W)),
                G_W'(gsum >> (GSUM_W - G_W)),
                B_W'(b >> (RAW_W - B_W))};
    endfunction

endpackage

// File: rtl/d5m_bayer_rgb565_if.sv
// Raw pixel stream from the D5M sampler, already in the clk domain.
interface d5m_bayer_rgb565_if;
    import d5m_pkg::*;

    logic             pix_valid;
    logic [RAW_W-1:0] pix_data;
    logic             fval;
    logic             lval;

    modport master (output pix_valid, pix_data, fval, lval);
    modport slave  (input  pix_valid, pix_data, fval, lval);

endinterface

// File: rtl/bayer_line_buffer.sv
// Simple dual-port line buffer holding {G1,R} per quad; read data registered and held between reads.
module bayer_line_buffer #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 24
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/d5m_bayer_rgb565.sv
// Converts a raw D5M Bayer stream into one RGB565 pixel per 2x2 quad, with frame/line framing checks.
module d5m_bayer_rgb565
    import d5m_pkg::*;
#(
    parameter int unsigned LINE_WIDTH  = 640,
    parameter int unsigned FRAME_LINES = 480
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    d5m_bayer_rgb565_if.slave   pix,
    output logic                out_valid,
    output logic [RGB_W-1:0]    out_data,
    output logic                out_sof,
    output logic                out_eol,
    output logic                frame_done,
    output logic                err_format,
    output logic [15:0]         frame_count
);

    localparam int unsigned QUADS  = LINE_WIDTH / 2;
    localparam int unsigned ADDR_W = (QUADS > 1) ? $clog2(QUADS) : 1;
    localparam int unsigned COL_W  = $clog2(LINE_WIDTH + 1);
    localparam int unsigned ROW_W  = $clog2(FRAME_LINES + 1);
    localparam int unsigned BUF_W  = 2 * RAW_W;
    localparam int unsigned CNT_W  = 16;

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [RAW_W-1:0]   g1_q, g1_d;
    logic [RAW_W-1:0]   b_q, b_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [RGB_W-1:0]   data_q, data_d;
    logic               sof_q, sof_d;
    logic               eol_q, eol_d;
    logic               done_q, done_d;
    logic               fval_q, lval_q;

    logic               fval_rise_c, fval_fall_c, lval_rise_c, lval_fall_c;
    logic               accept_c;
    logic [ADDR_W-1:0]  quad_c;
    logic               wr_en_c, rd_en_c;
    logic [BUF_W-1:0]   wr_data_c;
    logic [BUF_W-1:0]   rd_data;

    // Edge history is not reset so a frame already in flight cannot look like a fresh fval rise.
    always_ff @(posedge clk) begin
        fval_q <= pix.fval;
        lval_q <= pix.lval;
    end

    assign fval_rise_c = pix.fval & ~fval_q;
    assign fval_fall_c = ~pix.fval & fval_q;
    assign lval_rise_c = pix.lval & ~lval_q;
    assign lval_fall_c = ~pix.lval & lval_q;
    assign accept_c    = pix.pix_valid & pix.fval & pix.lval &
                         ((state_q == EVEN_LINE) || (state_q == ODD_LINE));
    assign quad_c      = ADDR_W'(col_q >> 1);
    assign wr_data_c   = {g1_q, pix.pix_data};

    bayer_line_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (BUF_W)
    ) u_line_buffer (
        .clk       (clk),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (quad_c),
        .wr_data_i (wr_data_c),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (quad_c),
        .rd_data_o (rd_data)
    );

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        g1_d    = g1_q;
        b_d     = b_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        data_d  = data_q;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        done_d  = 1'b0;
        wr_en_c = 1'b0;
        rd_en_c = 1'b0;

        case (state_q)
            WAIT_FRAME: begin
                if (fval_rise_c && enable) begin
                    state_d = WAIT_LINE;
                    row_d   = '0;
                end
            end
            WAIT_LINE: begin
                if (fval_fall_c) begin
                    state_d = WAIT_FRAME;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (lval_rise_c) begin
                    if (row_q >= ROW_W'(FRAME_LINES)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = row_q[0] ? ODD_LINE : EVEN_LINE;
                        col_d   = '0;
                    end
                end
            end
            EVEN_LINE, ODD_LINE: begin
                if (fval_fall_c) begin
                    state_d = WAIT_FRAME;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end else if (lval_fall_c) begin
                    if (col_q != COL_W'(LINE_WIDTH)) begin
                        err_d = 1'b1;
                    end
                    row_d   = row_q + ROW_W'(1);
                    state_d = WAIT_LINE;
                end else if (accept_c) begin
                    if (col_q >= COL_W'(LINE_WIDTH)) begin
                        err_d = 1'b1;
                    end else begin
                        col_d = col_q + COL_W'(1);
                        if (state_q == EVEN_LINE) begin
                            if (!col_q[0]) begin
                                g1_d = pix.pix_data;
                            end else begin
                                wr_en_c = 1'b1;
                            end
                        end else if (!col_q[0]) begin
                            b_d     = pix.pix_data;
                            rd_en_c = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = pack_rgb565(rd_data[RAW_W-1:0], rd_data[BUF_W-1:RAW_W],
                                                  pix.pix_data, b_q);
                            sof_d   = (quad_c == '0) && ((row_q >> 1) == '0);
                            eol_d   = (quad_c == ADDR_W'(QUADS - 1));
                        end
                    end
                end
            end
            default: state_d = WAIT_FRAME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= WAIT_FRAME;
            row_q   <= '0;
            col_q   <= '0;
            g1_q    <= '0;
            b_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            g1_q    <= g1_d;
            b_q     <= b_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            done_q  <= done_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_sof     = sof_q;
    assign out_eol     = eol_q;
    assign frame_done  = done_q;
    assign err_format  = err_q;
    assign frame_count = cnt_q;

endmodule

// File: tb/tb_d5m_bayer_rgb565.sv
// Directed bench: a 4x2 instance for the literal quad test, an 8x4 instance for framing and error cases.
module tb_d5m_bayer_rgb565;
    import d5m_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_b, en_a, en_b;
    logic        ov_a, sof_a, eol_a, fd_a, err_a;
    logic        ov_b, sof_b, eol_b, fd_b, err_b;
    logic [15:0] od_a, fc_a, od_b, fc_b;

    d5m_bayer_rgb565_if if_a ();
    d5m_bayer_rgb565_if if_b ();

    d5m_bayer_rgb565 #(.LINE_WIDTH(4), .FRAME_LINES(2)) dut_a (
        .clk(clk), .reset(reset_a), .enable(en_a), .pix(if_a),
        .out_valid(ov_a), .out_data(od_a), .out_sof(sof_a), .out_eol(eol_a),
        .frame_done(fd_a), .err_format(err_a), .frame_count(fc_a)
    );

    d5m_bayer_rgb565 #(.LINE_WIDTH(8), .FRAME_LINES(4)) dut_b (
        .clk(clk), .reset(reset_b), .enable(en_b), .pix(if_b),
        .out_valid(ov_b), .out_data(od_b), .out_sof(sof_b), .out_eol(eol_b),
        .frame_done(fd_b), .err_format(err_b), .frame_count(fc_b)
    );

    int checks = 0;
    int errors = 0;
    int fd_cnt_a = 0;
    int fd_cnt_b = 0;
    logic [17:0] exp_a[$];
    logic [17:0] exp_b[$];
    logic [17:0] ea, eb;
    logic [11:0] raw [0:7][0:11];

    // Expected RGB565 for quad q of row pair p, straight from the raw frame.
    function automatic logic [15:0] model_pix(input int p, input int q);
        int r5, g6, b5;
        r5 = int'(raw[2*p][2*q+1]) / 128;
        g6 = (int'(raw[2*p][2*q]) + int'(raw[2*p+1][2*q+1])) / 128;
        b5 = int'(raw[2*p+1][2*q]) / 128;
        return 16'(r5 * 2048 + g6 * 32 + b5);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (fd_a) fd_cnt_a++;
        if (fd_b) fd_cnt_b++;
        if (ov_a) begin
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL out_a unexpected pixel: got %h expected none", od_a);
            end else begin
                ea = exp_a.pop_front();
                if ({sof_a, eol_a, od_a} !== ea) begin
                    errors++;
                    $display("FAIL out_a pixel: got sof=%b eol=%b data=%h expected sof=%b eol=%b data=%h",
                             sof_a, eol_a, od_a, ea[17], ea[16], ea[15:0]);
                end
            end
        end
        if (ov_b) begin
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL out_b unexpected pixel: got %h expected none", od_b);
            end else begin
                eb = exp_b.pop_front();
                if ({sof_b, eol_b, od_b} !== eb) begin
                    errors++;
                    $display("FAIL out_b pixel: got sof=%b eol=%b data=%h expected sof=%b eol=%b data=%h",
                             sof_b, eol_b, od_b, eb[17], eb[16], eb[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fval(input int sel, input logic f);
        if (sel == 0) if_a.fval = f; else if_b.fval = f;
    endtask

    task automatic set_lval(input int sel, input logic l);
        if (sel == 0) if_a.lval = l; else if_b.lval = l;
    endtask

    task automatic set_pix(input int sel, input logic v, input logic [11:0] d);
        if (sel == 0) begin
            if_a.pix_valid = v;
            if_a.pix_data  = d;
        end else begin
            if_b.pix_valid = v;
            if_b.pix_data  = d;
        end
    endtask

    task automatic send_line(input int sel, input int row, input int npix, input bit close);
        set_lval(sel, 1'b1);
        set_pix(sel, 1'b0, 12'h0);
        tick();
        for (int c = 0; c < npix; c++) begin
            set_pix(sel, 1'b1, raw[row][c]);
            tick();
            set_pix(sel, 1'b0, 12'h0);
            tick();
        end
        if (close) begin
            set_lval(sel, 1'b0);
            tick();
            tick();
        end
    endtask

    task automatic frame_open(input int sel);
        set_fval(sel, 1'b1);
        tick();
        tick();
    endtask

    task automatic frame_close(input int sel);
        set_fval(sel, 1'b0);
        set_lval(sel, 1'b0);
        set_pix(sel, 1'b0, 12'h0);
        tick();
        tick();
        tick();
    endtask

    task automatic send_frame(input int sel, input int width, input int lines);
        frame_open(sel);
        for (int r = 0; r < lines; r++) send_line(sel, r, width, 1'b1);
        frame_close(sel);
    endtask

    task automatic rand_frame();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 12; c++)
                raw[r][c] = 12'($urandom);
    endtask

    task automatic expect_pair(input int p, input int nq);
        for (int q = 0; q < nq; q++)
            exp_b.push_back({(p == 0 && q == 0), (q == 3), model_pix(p, q)});
    endtask

    task automatic expect_full_frame_b();
        rand_frame();
        expect_pair(0, 4);
        expect_pair(1, 4);
        send_frame(1, 8, 4);
    endtask

    initial begin
        reset_a = 1'b1; reset_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        if_a.pix_valid = 1'b0; if_a.pix_data = '0; if_a.fval = 1'b0; if_a.lval = 1'b0;
        if_b.pix_valid = 1'b0; if_b.pix_data = '0; if_b.fval = 1'b0; if_b.lval = 1'b0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 12; c++) raw[r][c] = '0;
        tick(); tick(); tick();

        chk("reset out_valid", {31'd0, ov_a | ov_b}, 32'd0);
        chk("reset out_data", {od_a, od_b}, 32'd0);
        chk("reset flags", {28'd0, sof_a | sof_b, eol_a | eol_b, fd_a | fd_b, err_a | err_b}, 32'd0);
        chk("reset frame_count", {fc_a, fc_b}, 32'd0);
        reset_a = 1'b0; reset_b = 1'b0;
        tick(); tick();

        // Literal quad test on the 4x2 instance.
        raw[0][0] = 12'h800; raw[0][1] = 12'hFFF; raw[0][2] = 12'h000; raw[0][3] = 12'h000;
        raw[1][0] = 12'h000; raw[1][1] = 12'h800; raw[1][2] = 12'hFFF; raw[1][3] = 12'h000;
        chk("model pin q0", 32'(model_pix(0, 0)), 32'h0000FC00);
        chk("model pin q1", 32'(model_pix(0, 1)), 32'h0000001F);
        exp_a.push_back({1'b1, 1'b0, 16'hFC00});
        exp_a.push_back({1'b0, 1'b1, 16'h001F});
        send_frame(0, 4, 2);
        tick(); tick();
        chk("t1 frame_done pulses", 32'(fd_cnt_a), 32'd1);
        chk("t1 frame_count", 32'(fc_a), 32'd1);
        chk("t1 err_format", 32'(err_a), 32'd0);
        chk("t1 pixels drained", 32'(exp_a.size()), 32'd0);

        // Two random full frames.
        expect_full_frame_b();
        expect_full_frame_b();
        chk("t6 frame_count", 32'(fc_b), 32'd2);
        chk("t6 err_format", 32'(err_b), 32'd0);
        chk("t6 pixels drained", 32'(exp_b.size()), 32'd0);

        // Frame skipped when enable is low at fval rise.
        rand_frame();
        en_b = 1'b0;
        frame_open(1);
        en_b = 1'b1;
        for (int r = 0; r < 4; r++) send_line(1, r, 8, 1'b1);
        frame_close(1);
        chk("t2 skipped frame_count", 32'(fc_b), 32'd2);
        chk("t2 skipped frame_done", 32'(fd_cnt_b), 32'd2);
        expect_full_frame_b();
        chk("t2 next frame_count", 32'(fc_b), 32'd3);
        chk("t2 pixels drained", 32'(exp_b.size()), 32'd0);

        // fval and lval fall together mid odd row after three quads.
        rand_frame();
        expect_pair(0, 3);
        frame_open(1);
        send_line(1, 0, 8, 1'b1);
        send_line(1, 1, 6, 1'b0);
        frame_close(1);
        chk("t4 frame_count", 32'(fc_b), 32'd4);
        chk("t4 frame_done", 32'(fd_cnt_b), 32'd4);
        chk("t4 err_format", 32'(err_b), 32'd0);
        chk("t4 pixels drained", 32'(exp_b.size()), 32'd0);
        expect_full_frame_b();
        chk("t4 next frame_count", 32'(fc_b), 32'd5);
        chk("t4 next drained", 32'(exp_b.size()), 32'd0);

        // Overlong first line: extra pixels dropped, error sticky.
        rand_frame();
        expect_pair(0, 4);
        expect_pair(1, 4);
        frame_open(1);
        send_line(1, 0, 10, 1'b1);
        for (int r = 1; r < 4; r++) send_line(1, r, 8, 1'b1);
        frame_close(1);
        chk("t3 err_format", 32'(err_b), 32'd1);
        chk("t3 frame_count", 32'(fc_b), 32'd6);
        chk("t3 pixels drained", 32'(exp_b.size()), 32'd0);

        // Reset in the middle of an odd row.
        rand_frame();
        expect_pair(0, 1);
        frame_open(1);
        send_line(1, 0, 8, 1'b1);
        send_line(1, 1, 2, 1'b0);
        reset_b = 1'b1;
        tick();
        chk("t5 reset out_valid", 32'(ov_b), 32'd0);
        chk("t5 reset frame_count", 32'(fc_b), 32'd0);
        chk("t5 reset err_format", 32'(err_b), 32'd0);
        chk("t5 reset frame_done", 32'(fd_b), 32'd0);
        reset_b = 1'b0;
        for (int c = 2; c < 8; c++) begin
            set_pix(1, 1'b1, raw[1][c]);
            tick();
            set_pix(1, 1'b0, 12'h0);
            tick();
        end
        set_lval(1, 1'b0);
        tick(); tick();
        send_line(1, 2, 8, 1'b1);
        send_line(1, 3, 8, 1'b1);
        frame_close(1);
        chk("t5 no frame_done after reset", 32'(fd_cnt_b), 32'd6);
        chk("t5 frame_count after tail", 32'(fc_b), 32'd0);
        chk("t5 drained", 32'(exp_b.size()), 32'd0);
        expect_full_frame_b();
        chk("t5 next frame_count", 32'(fc_b), 32'd1);
        chk("t5 next err_format", 32'(err_b), 32'd0);

        tick(); tick(); tick(); tick();
        chk("final a drained", 32'(exp_a.size()), 32'd0);
        chk("final b drained", 32'(exp_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
